alu_instr_sequencer: RTL and testbench

- Issues queued ALU instruction words to the combinational ALU, one at a time.
- Waits a fixed settle time, then captures each 2×DATA_W result and returns it on a valid/ready result port.
- Sits between software or bench-side instruction loading and the ALU datapath. It is the driving end of the ALU instruction/result interface.

---
 rtl/alu_instr_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer
//
// Queues ALU instruction words and drives them, one at a time, into a purely
// combinational ALU. Each instruction is held on the alu_* outputs for SETTLE
// cycles before the ALU result is captured and offered on a valid/ready port.
//
// Ports
//   clk_i, rst_i        clock and synchronous active-high reset
//   ld_*                instruction load port (valid/ready), accepted in IDLE only
//   start_i             start draining the queue, sampled in IDLE only
//   busy_o, done_o      run status; done_o pulses once when the queue has drained
//   alu_*_o             registered instruction presented to the ALU
//   alu_result_i        combinational ALU result (2*DATA_W bits)
//   res_*               captured result, index in issue order and error flag

module alu_instr_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SETTLE = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    // Instruction load port
    input  logic                     ld_valid_i,
    output logic                     ld_ready_o,
    input  logic [2:0]               ld_opcode_i,
    input  logic                     ld_unsigned_i,
    input  logic [DATA_W-1:0]        ld_a_i,
    input  logic [DATA_W-1:0]        ld_b_i,

    // Run control
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,

    // ALU drive side
    output logic [2:0]               alu_opcode_o,
    output logic                     alu_unsigned_o,
    output logic [DATA_W-1:0]        alu_a_o,
    output logic [DATA_W-1:0]        alu_b_o,
    input  logic [2*DATA_W-1:0]      alu_result_i,

    // Result port
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [2*DATA_W-1:0]      res_data_o,
    output logic [$clog2(DEPTH)-1:0] res_index_o,
    output logic                     res_err_o
);

    // ------------------------------------------------------------------
    // Local parameters
    // ------------------------------------------------------------------
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // Queue entry layout: {opcode, unsigned, a, b}
    localparam int unsigned EW = 3 + 1 + 2 * DATA_W;

    localparam logic [CW-1:0] FullCount  = CW'(DEPTH);
    localparam logic [SW-1:0] SettleLoad = SW'(SETTLE - 1);

    localparam logic [2:0] OpDiv = 3'd3;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StIssue  = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StResult = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]          state_q, state_d;

    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;

    logic [SW-1:0]       settle_q, settle_d;

    logic [2:0]          alu_opcode_q, alu_opcode_d;
    logic                alu_unsigned_q, alu_unsigned_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;

    logic [2*DATA_W-1:0] res_data_q, res_data_d;
    logic [AW-1:0]       res_index_q, res_index_d;
    logic                res_err_q, res_err_d;

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic [EW-1:0] ld_entry;

    assign ld_ready_o = (state_q == StIdle) && (count_q != FullCount);
    assign push       = ld_valid_i && ld_ready_o;
    assign pop        = (state_q == StIssue);
    assign head       = mem_q[rd_ptr_q];
    assign ld_entry   = {ld_opcode_i, ld_unsigned_i, ld_a_i, ld_b_i};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // push and pop are mutually exclusive by state, but stay exact anyway
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Error detection on the instruction currently held on the ALU
    // ------------------------------------------------------------------
    logic illegal_op;
    logic div_by_zero;
    logic err_now;

    // Opcodes 6 and 7 are the only encodings with both upper bits set
    assign illegal_op  = alu_opcode_q[2] && alu_opcode_q[1];
    assign div_by_zero = (alu_opcode_q == OpDiv) && (alu_b_q == '0);
    assign err_now     = illegal_op || div_by_zero;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        settle_d       = settle_q;
        alu_opcode_d   = alu_opcode_q;
        alu_unsigned_d = alu_unsigned_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        res_data_d     = res_data_q;
        res_index_d    = res_index_q;
        res_err_d      = res_err_q;

        unique case (state_q)
            StIdle: begin
                // count_q is the pre-push value, so a same-cycle load is not
                // part of the run being started
                if (start_i) begin
                    if (count_q != '0) begin
                        state_d     = StIssue;
                        res_index_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            StIssue: begin
                alu_opcode_d   = head[EW-1 -: 3];
                alu_unsigned_d = head[EW-4];
                alu_a_d        = head[2*DATA_W-1 -: DATA_W];
                alu_b_d        = head[DATA_W-1:0];
                settle_d       = SettleLoad;
                state_d        = StWait;
            end

            StWait: begin
                if (settle_q == '0) begin
                    state_d    = StResult;
                    res_err_d  = err_now;
                    res_data_d = err_now ? '0 : alu_result_i;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end

            StResult: begin
                if (res_ready_i) begin
                    res_index_d = res_index_q + 1'b1;
                    state_d     = (count_q != '0) ? StIssue : StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            settle_q       <= '0;
            alu_opcode_q   <= '0;
            alu_unsigned_q <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            res_data_q     <= '0;
            res_index_q    <= '0;
            res_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            settle_q       <= settle_d;
            alu_opcode_q   <= alu_opcode_d;
            alu_unsigned_q <= alu_unsigned_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            res_data_q     <= res_data_d;
            res_index_q    <= res_index_d;
            res_err_q      <= res_err_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by count_q alone
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ld_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy_o         = (state_q != StIdle);
    assign done_o         = (state_q == StDone);
    assign res_valid_o    = (state_q == StResult);
    assign res_data_o     = res_data_q;
    assign res_index_o    = res_index_q;
    assign res_err_o      = res_err_q;
    assign alu_opcode_o   = alu_opcode_q;
    assign alu_unsigned_o = alu_unsigned_q;
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;

    // ------------------------------------------------------------------
    // Protocol assertions
    // ------------------------------------------------------------------
    // A pending result may only be withdrawn by a handshake
    assert property (@(posedge clk_i) disable iff (rst_i)
        res_valid_o && !res_ready_i |=> res_valid_o);

    // Never issue from an empty queue
    assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == StIssue) |-> (count_q != '0));

    // done is a single-cycle pulse that returns to IDLE
    assert property (@(posedge clk_i) disable iff (rst_i)
        done_o |=> !busy_o);

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer with a behavioural
// combinational ALU attached to the alu_* outputs.

module tb_alu_instr_sequencer;

    localparam int unsigned W      = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned IW     = $clog2(DEPTH);
    localparam int          LAT    = SETTLE + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            ld_valid;
    logic            ld_ready;
    logic [2:0]      ld_opcode;
    logic            ld_unsigned;
    logic [W-1:0]    ld_a;
    logic [W-1:0]    ld_b;
    logic            start;
    logic            busy;
    logic            done;
    logic [2:0]      alu_opcode;
    logic            alu_unsigned;
    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [2*W-1:0]  alu_result;
    logic            res_valid;
    logic            res_ready;
    logic [2*W-1:0]  res_data;
    logic [IW-1:0]   res_index;
    logic            res_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_instr_sequencer #(
        .DATA_W (W),
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ld_valid_i     (ld_valid),
        .ld_ready_o     (ld_ready),
        .ld_opcode_i    (ld_opcode),
        .ld_unsigned_i  (ld_unsigned),
        .ld_a_i         (ld_a),
        .ld_b_i         (ld_b),
        .start_i        (start),
        .busy_o         (busy),
        .done_o         (done),
        .alu_opcode_o   (alu_opcode),
        .alu_unsigned_o (alu_unsigned),
        .alu_a_o        (alu_a),
        .alu_b_o        (alu_b),
        .alu_result_i   (alu_result),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_data_o     (res_data),
        .res_index_o    (res_index),
        .res_err_o      (res_err)
    );

    // Behavioural ALU; error cases return nonzero junk so forcing to 0 is visible
    logic [2*W-1:0] ea, eb;
    always_comb begin
        ea = alu_unsigned ? {{W{1'b0}}, alu_a} : {{W{alu_a[W-1]}}, alu_a};
        eb = alu_unsigned ? {{W{1'b0}}, alu_b} : {{W{alu_b[W-1]}}, alu_b};
        alu_result = 64'hDEAD_BEEF_0BAD_F00D;
        case (alu_opcode)
            3'd0: alu_result = ea + eb;
            3'd1: alu_result = ea - eb;
            3'd2: alu_result = ea * eb;
            3'd3: begin
                if (alu_b == '0)        alu_result = '1;
                else if (alu_unsigned)  alu_result = {alu_a % alu_b, alu_a / alu_b};
                else alu_result = {W'($signed(alu_a) % $signed(alu_b)),
                                   W'($signed(alu_a) / $signed(alu_b))};
            end
            3'd4: alu_result = ea << alu_b[4:0];
            3'd5: alu_result = alu_unsigned ? (ea >> alu_b[4:0])
                                            : 64'($signed(ea) >>> alu_b[4:0]);
            default: alu_result = 64'hDEAD_BEEF_0BAD_F00D;
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] op, input logic uns,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!ld_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("ld_ready_wait", 64'(n), 64'd0);
        ld_valid    = 1'b1;
        ld_opcode   = op;
        ld_unsigned = uns;
        ld_a        = a;
        ld_b        = b;
        @(negedge clk);
        ld_valid    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles from the triggering event (1 = first cycle after it) until
    // res_valid, then checks the payload; steps past the handshake if ready.
    task automatic expect_result(input string tag, input int exp_wait,
                                 input logic [63:0] data, input logic [IW-1:0] idx,
                                 input logic err);
        int n;
        n = 1;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, ".lat"},  64'(n), 64'(exp_wait));
        check_eq({tag, ".data"}, res_data, data);
        check_eq({tag, ".idx"},  64'(res_index), 64'(idx));
        check_eq({tag, ".err"},  64'(res_err), 64'(err));
        if (res_ready) @(negedge clk);
    endtask

    // Called one cycle after the last handshake
    task automatic finish_run(input string tag);
        check_eq({tag, ".done"}, 64'(done), 64'd1);
        @(negedge clk);
        check_eq({tag, ".done_clr"}, 64'(done), 64'd0);
        check_eq({tag, ".idle"},     64'(busy), 64'd0);
        check_eq({tag, ".ld_rdy"},   64'(ld_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        rst = 1'b1; ld_valid = 1'b0; ld_opcode = '0; ld_unsigned = 1'b0;
        ld_a = '0; ld_b = '0; start = 1'b0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_eq("rst.ld_ready",  64'(ld_ready), 64'd1);
        check_eq("rst.busy",      64'(busy), 64'd0);
        check_eq("rst.done",      64'(done), 64'd0);
        check_eq("rst.res_valid", 64'(res_valid), 64'd0);
        check_eq("rst.res_data",  res_data, 64'd0);
        check_eq("rst.res_index", 64'(res_index), 64'd0);
        check_eq("rst.res_err",   64'(res_err), 64'd0);
        check_eq("rst.alu_a",     64'(alu_a), 64'd0);
        check_eq("rst.alu_op",    64'(alu_opcode), 64'd0);

        // Signed add
        load(3'd0, 1'b0, 32'h10, 32'h20);
        pulse_start();
        check_eq("add.busy",   64'(busy), 64'd1);
        check_eq("add.ld_blk", 64'(ld_ready), 64'd0);
        expect_result("add", LAT, 64'h30, 0, 1'b0);
        finish_run("add");

        // Mixed sequence
        load(3'd1, 1'b0, 32'h10, 32'h20);
        load(3'd2, 1'b1, 32'hFFFF_FFFF, 32'h2);
        load(3'd4, 1'b0, 32'h1, 32'h4);
        pulse_start();
        expect_result("sub", LAT, 64'hFFFF_FFFF_FFFF_FFF0, 0, 1'b0);
        expect_result("mul", LAT, 64'h1_FFFF_FFFE, 1, 1'b0);
        expect_result("sl",  LAT, 64'h10, 2, 1'b0);
        finish_run("mix");

        // Full queue, rejected 17th load, backpressure
        for (int i = 0; i < 16; i++) load(3'd0, 1'b0, 32'h100 + W'(i), 32'h0);
        check_eq("full.ld_ready", 64'(ld_ready), 64'd0);
        ld_valid = 1'b1; ld_opcode = 3'd0; ld_a = 32'hAAAA; ld_b = 32'h0;
        @(negedge clk);
        ld_valid = 1'b0;
        res_ready = 1'b0;
        pulse_start();
        expect_result("bp", LAT, 64'h100, 0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("bp.valid_hold", 64'(res_valid), 64'd1);
            check_eq("bp.data_hold",  res_data, 64'h100);
            check_eq("bp.idx_hold",   64'(res_index), 64'd0);
        end
        res_ready = 1'b1;
        expect_result("bp.rel", 1, 64'h100, 0, 1'b0);
        for (int i = 1; i < 16; i++)
            expect_result("full", LAT, 64'h100 + 64'(i), IW'(i), 1'b0);
        finish_run("full");

        // Errors
        load(3'd3, 1'b0, 32'd7, 32'd0);
        load(3'd7, 1'b0, 32'd3, 32'd4);
        load(3'd0, 1'b0, 32'd1, 32'd1);
        pulse_start();
        expect_result("div0",  LAT, 64'd0, 0, 1'b1);
        expect_result("op7",   LAT, 64'd0, 1, 1'b1);
        expect_result("after", LAT, 64'd2, 2, 1'b0);
        finish_run("err");

        // Start on an empty queue
        pulse_start();
        check_eq("empty.done",  64'(done), 64'd1);
        check_eq("empty.valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        check_eq("empty.done_clr", 64'(done), 64'd0);
        check_eq("empty.busy",     64'(busy), 64'd0);

        // Load and start in the same cycle: start sees the pre-push count
        ld_valid = 1'b1; ld_opcode = 3'd0; ld_unsigned = 1'b0; ld_a = 32'h40; ld_b = 32'h2;
        start = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; start = 1'b0;
        check_eq("same.done",  64'(done), 64'd1);
        check_eq("same.valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        pulse_start();
        expect_result("same.late", LAT, 64'h42, 0, 1'b0);
        finish_run("same");

        // Start while busy is ignored
        load(3'd0, 1'b0, 32'd5, 32'd5);
        load(3'd0, 1'b0, 32'd6, 32'd6);
        pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_result("bs0", LAT - 1, 64'd10, 0, 1'b0);
        expect_result("bs1", LAT, 64'd12, 1, 1'b0);
        finish_run("bs");
        highs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid || busy) highs++;
        end
        check_eq("bs.no_extra", 64'(highs), 64'd0);

        // Reset in RESULT of entry 1
        for (int k = 0; k < 4; k++) load(3'd0, 1'b0, 32'h1000 + W'(k), 32'h0);
        pulse_start();
        expect_result("rr0", LAT, 64'h1000, 0, 1'b0);
        res_ready = 1'b0;
        expect_result("rr1", LAT, 64'h1001, 1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rr.valid",    64'(res_valid), 64'd0);
        check_eq("rr.busy",     64'(busy), 64'd0);
        check_eq("rr.ld_ready", 64'(ld_ready), 64'd1);
        check_eq("rr.index",    64'(res_index), 64'd0);
        check_eq("rr.data",     res_data, 64'd0);
        res_ready = 1'b1;
        pulse_start();
        check_eq("rr.done",  64'(done), 64'd1);
        check_eq("rr.valid2", 64'(res_valid), 64'd0);
        highs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid) highs++;
        end
        check_eq("rr.no_results", 64'(highs), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
